// File: rtl/v_ex_1.sv
// v_ex_1: vector execute/writeback stage, element-wise VADD/VMUL over LANES elements per cycle
module v_ex_1 #(
  parameter int VLMAX     = 8,
  parameter int VALUOP_DW = 5,
  parameter int VREG_DW   = 256,
  parameter int VREG_AW   = 5,
  parameter int SEW       = 32,
  parameter int LANES     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vid_valid_i,
  output logic                 vid_ready_o,
  input  logic [VALUOP_DW-1:0] valu_opcode_i,
  input  logic [VREG_DW-1:0]   operand_v1_i,
  input  logic [VREG_DW-1:0]   operand_v2_i,
  input  logic                 vid_wb_en_i,
  input  logic [VREG_AW-1:0]   vid_wb_addr_i,
  output logic                 vwb_en_o,
  output logic [VREG_AW-1:0]   vwb_addr_o,
  output logic [VREG_DW-1:0]   vwb_data_o,
  output logic                 busy_o
);
  localparam int CW = $clog2(VLMAX);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [VALUOP_DW-1:0] r_op;
  logic [VREG_DW-1:0]   r_v1, r_v2, r_buf, r_wb_data, w_buf;
  logic [VREG_AW-1:0]   r_vd, r_wb_addr;
  logic                 r_wb_en, w_go, w_last;
  assign vid_ready_o = r_state == IDLE && !rst;
  assign busy_o      = r_state != IDLE;
  assign w_go        = vid_valid_i && vid_ready_o && vid_wb_en_i &&
                       (valu_opcode_i == VALUOP_DW'(1) || valu_opcode_i == VALUOP_DW'(2));
  assign w_last      = int'(r_cnt) + LANES == VLMAX;
  // write strobe is suppressed in the reset cycle so an abandoned op never writes
  assign vwb_en_o    = r_wb_en && !rst;
  assign vwb_addr_o  = rst ? '0 : r_wb_addr;
  assign vwb_data_o  = rst ? '0 : r_wb_data;
  always_comb begin
    w_buf = r_buf;
    for (int l = 0; l < LANES; l++)
      w_buf[(int'(r_cnt) + l)*SEW +: SEW] = r_op == VALUOP_DW'(2) ?
        r_v1[(int'(r_cnt) + l)*SEW +: SEW] * r_v2[(int'(r_cnt) + l)*SEW +: SEW] :
        r_v1[(int'(r_cnt) + l)*SEW +: SEW] + r_v2[(int'(r_cnt) + l)*SEW +: SEW];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_buf     <= '0;
      r_op      <= '0;
      r_v1      <= '0;
      r_v2      <= '0;
      r_vd      <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else begin
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      if (vid_valid_i && vid_ready_o) begin
        r_op <= valu_opcode_i;
        r_v1 <= operand_v1_i;
        r_v2 <= operand_v2_i;
        r_vd <= vid_wb_addr_i;
        if (w_go) begin
          r_cnt   <= '0;
          r_state <= EXEC;
        end
      end
      if (r_state == EXEC) begin
        r_buf <= w_buf;
        r_cnt <= r_cnt + CW'(LANES);
        if (w_last) begin
          r_state   <= WB;
          r_wb_en   <= 1'b1;
          r_wb_addr <= r_vd;
          r_wb_data <= w_buf;
        end
      end
      if (r_state == WB) r_state <= IDLE;
    end
  end
endmodule
